// File: rtl/multi_line_buffer_if.sv
// Pixel stream bundle for the multi-line buffer: qualified pixel input on one
// side, registered vertical tap column and fill status on the other.
//
// Handshake: there is no back-pressure. The source presents col/pixel_in with
// pixel_valid=1 for exactly the cycles it wants a pixel taken; the buffer
// always consumes in that cycle. sof is sampled every cycle regardless of
// pixel_valid. taps_valid is a one-cycle qualifier on taps_out.
interface multi_line_buffer_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int COL_WIDTH   = 10,
    parameter int NUM_LINES   = 3
);
    logic                             sof;
    logic                             pixel_valid;
    logic [COL_WIDTH-1:0]             col;
    logic [PIXEL_WIDTH-1:0]           pixel_in;
    logic [NUM_LINES*PIXEL_WIDTH-1:0] taps_out;
    logic                             taps_valid;
    logic [COL_WIDTH-1:0]             lines_filled;

    // Video source side.
    modport master (
        output sof, pixel_valid, col, pixel_in,
        input  taps_out, taps_valid, lines_filled
    );

    // Line buffer side.
    modport slave (
        input  sof, pixel_valid, col, pixel_in,
        output taps_out, taps_valid, lines_filled
    );
endinterface

// File: rtl/multi_line_buffer.sv
// Multi-line delay buffer: keeps NUM_LINES-1 previous video lines and presents
// a registered vertical column of NUM_LINES taps for the pixel being accepted.
// tap 0 is the current pixel, tap k is the same column k lines earlier.
// Memories are never cleared; taps_valid masks stale content until enough
// lines of the current frame have been written.
module multi_line_buffer #(
    parameter int WIDTH       = 640,
    parameter int PIXEL_WIDTH = 8,
    parameter int COL_WIDTH   = 10,
    parameter int NUM_LINES   = 3
) (
    input logic                clk,
    input logic                rst,
    multi_line_buffer_if.slave bus
);
    // Address width just wide enough for WIDTH entries.
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                             accept;
    logic                             is_last_col;
    logic                             fill_full;
    logic [AW-1:0]                    addr;
    logic [COL_WIDTH-1:0]             fill_q;
    logic                             taps_valid_q;
    logic [NUM_LINES*PIXEL_WIDTH-1:0] taps_q;
    logic [PIXEL_WIDTH-1:0]           rd_data [NUM_LINES-1];
    logic [PIXEL_WIDTH-1:0]           wr_data [NUM_LINES-1];

    // Out-of-range columns are dropped silently; only qualified in-range
    // pixels touch memory, taps or fill count.
    assign accept      = bus.pixel_valid && (32'(bus.col) < WIDTH);
    assign is_last_col = (32'(bus.col) == WIDTH - 1);
    assign fill_full   = (32'(fill_q) >= NUM_LINES - 1);

    // The low bits are a valid address whenever accept is high.
    assign addr = bus.col[AW-1:0];

    // Each line memory is read and written at the same address in the same
    // cycle (read-before-write), so a column ripples one line deeper per
    // accept: line 0 takes the new pixel, line k takes what line k-1 held.
    for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_line
        logic [PIXEL_WIDTH-1:0] mem [WIDTH];

        if (k == 0) begin : g_head
            assign wr_data[k] = bus.pixel_in;
        end else begin : g_tail
            assign wr_data[k] = rd_data[k-1];
        end

        assign rd_data[k] = mem[addr];

        // Line memory write; contents deliberately survive reset.
        always_ff @(posedge clk) begin
            if (accept && !rst) begin
                mem[addr] <= wr_data[k];
            end
        end
    end

    // Tap column register: loads the full column on accept, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= '0;
        end else if (accept) begin
            taps_q[PIXEL_WIDTH-1:0] <= bus.pixel_in;
            for (int k = 1; k < NUM_LINES; k++) begin
                taps_q[k*PIXEL_WIDTH +: PIXEL_WIDTH] <= rd_data[k-1];
            end
        end
    end

    // Column is trustworthy only when enough lines of this frame precede it;
    // an sof pixel starts a new frame and is never a full column.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_valid_q <= 1'b0;
        end else begin
            taps_valid_q <= accept && !bus.sof && fill_full;
        end
    end

    // Completed-line counter for the current frame, saturating at
    // NUM_LINES-1; only an accepted last-column pixel closes a line.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else if (bus.sof) begin
            fill_q <= (accept && is_last_col) ? COL_WIDTH'(1) : '0;
        end else if (accept && is_last_col && !fill_full) begin
            fill_q <= fill_q + COL_WIDTH'(1);
        end
    end

    assign bus.taps_out     = taps_q;
    assign bus.taps_valid   = taps_valid_q;
    assign bus.lines_filled = fill_q;
endmodule

// File: tb/tb_multi_line_buffer.sv
// Bench for multi_line_buffer: a small 8-column / 3-tap instance for the
// streaming, stall, out-of-range, sof and mid-line reset cases, and a
// 640-column / 5-tap instance for the wide configuration.
module tb_multi_line_buffer;
    localparam int W   = 8;
    localparam int PW  = 8;
    localparam int CW  = 4;
    localparam int NL  = 3;
    localparam int BW  = 640;
    localparam int BCW = 10;
    localparam int BNL = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_line_buffer_if #(.PIXEL_WIDTH(PW), .COL_WIDTH(CW),  .NUM_LINES(NL))  bus ();
    multi_line_buffer_if #(.PIXEL_WIDTH(PW), .COL_WIDTH(BCW), .NUM_LINES(BNL)) bus_big ();

    multi_line_buffer #(.WIDTH(W), .PIXEL_WIDTH(PW), .COL_WIDTH(CW), .NUM_LINES(NL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_line_buffer #(.WIDTH(BW), .PIXEL_WIDTH(PW), .COL_WIDTH(BCW), .NUM_LINES(BNL)) dut_big (
        .clk (clk),
        .rst (rst),
        .bus (bus_big)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [NL*PW-1:0] taps;
        logic             taps_known;
        logic             valid;
        logic [CW-1:0]    filled;
    } exp_t;

    typedef struct {
        logic          sof;
        logic          valid;
        int            col;
        logic [7:0]    pix;
        logic [23:0]   taps;
        logic          tv;
        logic [CW-1:0] lf;
    } vec_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model state (small instance).
    int               mfill;
    logic [NL*PW-1:0] mtaps;
    logic             mtaps_known;
    bit               hand_chk;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * 16 + c) & 255);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t model_step(input logic s, input logic v, input int c,
                                        input logic [7:0] p, input int row);
        exp_t e;
        logic acc;
        acc     = v && (c < W);
        e.valid = acc && !s && (mfill >= NL - 1);
        if (acc) begin
            if (e.valid) begin
                mtaps[PW-1:0] = p;
                for (int k = 1; k < NL; k++) mtaps[k*PW +: PW] = pix(row - k, c);
                mtaps_known = 1'b1;
            end else begin
                mtaps_known = 1'b0;
            end
        end
        if (s) mfill = (acc && c == W - 1) ? 1 : 0;
        else if (acc && c == W - 1 && mfill < NL - 1) mfill++;
        e.taps       = mtaps;
        e.taps_known = mtaps_known;
        e.filled     = CW'(mfill);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty: got no expectation, required one");
        end else begin
            e = exp_q.pop_front();
            check("taps_valid", 64'(bus.taps_valid), 64'(e.valid));
            check("lines_filled", 64'(bus.lines_filled), 64'(e.filled));
            if (e.taps_known) check("taps_out", 64'(bus.taps_out), 64'(e.taps));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input logic s, input logic v, input int c, input logic [7:0] p,
                         input exp_t e);
        bus.sof         = s;
        bus.pixel_valid = v;
        bus.col         = CW'(c);
        bus.pixel_in    = p;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic drive(input logic s, input logic v, input int c, input logic [7:0] p,
                         input int row);
        exp_t e;
        e = model_step(s, v, c, p, row);
        apply(s, v, c, p, e);
    endtask

    task automatic stream_row(input int row, input int start_col, input bit gaps);
        for (int c = start_col; c < W; c++) begin
            if (gaps && (c == 3 || c == 5)) begin
                int n;
                n = int'($urandom_range(1, 3));
                for (int g = 0; g < n; g++)
                    drive(1'b0, 1'b0, int'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), row);
            end
            drive(1'b0, 1'b1, c, pix(row, c), row);
            if (hand_chk && row == 2 && c == 5)
                check("row2_col5_taps", 64'(bus.taps_out), 64'h051525);
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        bus.sof             = 1'b0;
        bus.pixel_valid     = 1'b0;
        bus.col             = '0;
        bus.pixel_in        = '0;
        bus_big.sof         = 1'b0;
        bus_big.pixel_valid = 1'b0;
        bus_big.col         = '0;
        bus_big.pixel_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        mfill       = 0;
        mtaps       = '0;
        mtaps_known = 1'b1;
        check("rst_taps_out", 64'(bus.taps_out), 64'h0);
        check("rst_taps_valid", 64'(bus.taps_valid), 64'h0);
        check("rst_lines_filled", 64'(bus.lines_filled), 64'h0);
        check("rst_big_taps_valid", 64'(bus_big.taps_valid), 64'h0);
        check("rst_big_lines_filled", 64'(bus_big.lines_filled), 64'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[16];
        exp_t e;
        int   cnt;
        int   efill;
        logic [BNL*PW-1:0] etaps;

        // Row 2 with stalls and an out-of-range column, then sof on row 3.
        vecs[0]  = '{1'b0, 1'b1, 0, 8'h20, 24'h001020, 1'b1, 4'd2};
        vecs[1]  = '{1'b0, 1'b0, 3, 8'hAA, 24'h001020, 1'b0, 4'd2};
        vecs[2]  = '{1'b0, 1'b1, 1, 8'h21, 24'h011121, 1'b1, 4'd2};
        vecs[3]  = '{1'b0, 1'b1, 9, 8'h99, 24'h011121, 1'b0, 4'd2};
        vecs[4]  = '{1'b0, 1'b0, 2, 8'h55, 24'h011121, 1'b0, 4'd2};
        vecs[5]  = '{1'b0, 1'b0, 7, 8'h66, 24'h011121, 1'b0, 4'd2};
        vecs[6]  = '{1'b0, 1'b1, 2, 8'h22, 24'h021222, 1'b1, 4'd2};
        vecs[7]  = '{1'b0, 1'b1, 3, 8'h23, 24'h031323, 1'b1, 4'd2};
        vecs[8]  = '{1'b0, 1'b0, 0, 8'h00, 24'h031323, 1'b0, 4'd2};
        vecs[9]  = '{1'b0, 1'b1, 4, 8'h24, 24'h041424, 1'b1, 4'd2};
        vecs[10] = '{1'b0, 1'b1, 5, 8'h25, 24'h051525, 1'b1, 4'd2};
        vecs[11] = '{1'b0, 1'b1, 6, 8'h26, 24'h061626, 1'b1, 4'd2};
        vecs[12] = '{1'b0, 1'b1, 7, 8'h27, 24'h071727, 1'b1, 4'd2};
        vecs[13] = '{1'b1, 1'b1, 0, 8'h30, 24'h102030, 1'b0, 4'd0};
        vecs[14] = '{1'b0, 1'b1, 1, 8'h31, 24'h112131, 1'b0, 4'd0};
        vecs[15] = '{1'b1, 1'b0, 0, 8'h00, 24'h112131, 1'b0, 4'd0};

        hand_chk = 1'b0;

        // Plain streaming of rows 0..3.
        do_reset();
        hand_chk = 1'b1;
        for (int r = 0; r < 4; r++) stream_row(r, 0, 1'b0);
        hand_chk = 1'b0;

        // Stalls, out-of-range column and sof from the vector table.
        do_reset();
        stream_row(0, 0, 1'b0);
        stream_row(1, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            e.taps       = vecs[i].taps;
            e.taps_known = 1'b1;
            e.valid      = vecs[i].tv;
            e.filled     = vecs[i].lf;
            apply(vecs[i].sof, vecs[i].valid, vecs[i].col, vecs[i].pix, e);
        end
        mfill       = 0;
        mtaps_known = 1'b0;

        // New frame: rows 3 and 4 fill, row 5 is the first valid row.
        stream_row(3, 2, 1'b0);
        stream_row(4, 0, 1'b1);
        stream_row(5, 0, 1'b0);
        stream_row(6, 0, 1'b1);

        // Reset in the middle of row 7.
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, c, pix(7, c), 7);
        rst             = 1'b1;
        bus.sof         = 1'b0;
        bus.pixel_valid = 1'b1;
        bus.col         = CW'(4);
        bus.pixel_in    = pix(7, 4);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mfill       = 0;
        mtaps       = '0;
        mtaps_known = 1'b1;
        check("midrst_taps_out", 64'(bus.taps_out), 64'h0);
        check("midrst_taps_valid", 64'(bus.taps_valid), 64'h0);
        check("midrst_lines_filled", 64'(bus.lines_filled), 64'h0);
        stream_row(8, 0, 1'b0);
        stream_row(9, 0, 1'b1);
        stream_row(10, 0, 1'b0);
        bus.pixel_valid = 1'b0;

        // Wide configuration: incrementing pixels, 12 rows.
        cnt = 0;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < BW; c++) begin
                bus_big.sof         = 1'b0;
                bus_big.pixel_valid = 1'b1;
                bus_big.col         = BCW'(c);
                bus_big.pixel_in    = 8'(cnt);
                @(posedge clk);
                #1;
                efill = r + ((c == BW - 1) ? 1 : 0);
                if (efill > BNL - 1) efill = BNL - 1;
                check("big_lines_filled", 64'(bus_big.lines_filled), 64'(efill));
                check("big_taps_valid", 64'(bus_big.taps_valid), 64'(r >= BNL - 1));
                if (r >= BNL - 1) begin
                    for (int k = 0; k < BNL; k++) etaps[k*PW +: PW] = 8'(cnt - k * BW);
                    check("big_taps_out", 64'(bus_big.taps_out), 64'(etaps));
                end
                cnt++;
            end
        end
        bus_big.pixel_valid = 1'b0;
        @(posedge clk);
        #1;
        check("big_idle_taps_valid", 64'(bus_big.taps_valid), 64'h0);
        check("big_saturated_fill", 64'(bus_big.lines_filled), 64'(BNL - 1));
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
